bin_window_gen: RTL and testbench

Binary 3x3 neighbourhood generator for the morphology path. Accepts a raster-order stream of 1-bit pixels, buffers the two previous image rows internally, and emits one 9-bit window per interior pixel. The 9-bit window and its valid strobe feed the morphology operator blocks, which reduce each window to one output pixel. Every input beat is accepted; the block has no backpressure.

---
 rtl/bin_window_gen.sv | 106 ++++++++++
 tb/tb_bin_window_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bin_window_gen.sv
// Binary 3x3 window generator: two internal line buffers feed a sliding 3x3 window over a raster pixel stream.
// Optional macro WIN_PIPE_EN adds one output register stage (latency 2 instead of 1).
module bin_window_gen #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_pixel,
   input  logic       i_pixel_valid,
   output logic [8:0] o_pixel_data,
   output logic       o_pixel_data_valid,
   output logic       o_frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          lb0 [IMG_WIDTH];
   logic          lb1 [IMG_WIDTH];
   logic [8:0]    win;
   logic [8:0]    win_next;
   logic          col_last;
   logic          row_last;
   logic          interior;
   logic          emit;
   logic [8:0]    data_q;
   logic          valid_q;
   logic          done_q;

   // Bit 3*wr+wc: each row shifts toward wc=0 and the new right column enters at wc=2.
   always_comb begin
      col_last = (col == CW'(IMG_WIDTH - 1));
      row_last = (row == RW'(IMG_HEIGHT - 1));
      interior = (row >= RW'(2)) && (col >= CW'(2));
      emit     = i_pixel_valid && interior;
      win_next = {i_pixel, win[8:7], lb0[col], win[5:4], lb1[col], win[2:1]};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         col <= '0;
         row <= '0;
         win <= '0;
      end else if (i_pixel_valid) begin
         win <= win_next;
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Line buffers carry no reset; the interior gate keeps stale rows out of any emitted window.
   always_ff @(posedge i_clk) begin
      if (i_pixel_valid) begin
         lb1[col] <= lb0[col];
         lb0[col] <= i_pixel;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         valid_q <= emit;
         done_q  <= emit && row_last && col_last;
         if (emit) begin
            data_q <= win_next;
         end
      end
   end

`ifdef WIN_PIPE_EN
   logic [8:0] data_p;
   logic       valid_p;
   logic       done_p;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         data_p  <= '0;
         valid_p <= 1'b0;
         done_p  <= 1'b0;
      end else begin
         data_p  <= data_q;
         valid_p <= valid_q;
         done_p  <= done_q;
      end
   end

   assign o_pixel_data       = data_p;
   assign o_pixel_data_valid = valid_p;
   assign o_frame_done       = done_p;
`else
   assign o_pixel_data       = data_q;
   assign o_pixel_data_valid = valid_q;
   assign o_frame_done       = done_q;
`endif

endmodule

// File: tb/tb_bin_window_gen.sv
// Directed table-driven bench for bin_window_gen on a 5x4 image (6 windows per frame).
// Expected windows are hand-computed; WIN_PIPE_EN shifts expectations by one extra cycle.
module tb_bin_window_gen;

   localparam int W = 5;
   localparam int H = 4;
`ifdef WIN_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pixel;
   logic       pixel_valid;
   logic [8:0] data;
   logic       data_valid;
   logic       frame_done;

   typedef struct {
      logic       valid;
      logic       pixel;
      logic       exp_valid;
      logic [8:0] exp_data;
      logic       exp_done;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_miss   = 0;

   bin_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_pixel            (pixel),
      .i_pixel_valid      (pixel_valid),
      .o_pixel_data       (data),
      .o_pixel_data_valid (data_valid),
      .o_frame_done       (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One full frame; bit i of pix is raster pixel i, window k sits at wins[9k +: 9].
   task automatic add_frame(input logic [19:0] pix, input logic [53:0] wins, input bit toggle);
      vec_t v;
      int   w;
      w = 0;
      for (int i = 0; i < W * H; i++) begin
         v.valid     = 1'b1;
         v.pixel     = pix[i];
         v.exp_valid = ((i / W) >= 2) && ((i % W) >= 2);
         v.exp_data  = v.exp_valid ? wins[9*w +: 9] : 9'h000;
         v.exp_done  = (i == W * H - 1);
         if (v.exp_valid) w++;
         vecs.push_back(v);
         if (toggle) begin
            v.valid     = 1'b0;
            v.pixel     = ~pix[i];
            v.exp_valid = 1'b0;
            v.exp_data  = 9'h000;
            v.exp_done  = 1'b0;
            vecs.push_back(v);
         end
      end
   endtask

   task automatic add_partial(input int n);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.valid     = 1'b1;
         v.pixel     = 1'b1;
         v.exp_valid = 1'b0;
         v.exp_data  = 9'h000;
         v.exp_done  = 1'b0;
         vecs.push_back(v);
      end
   endtask

   task automatic check_output(input string name, input int k, input logic ev,
                               input logic [8:0] ed, input logic edone);
      check($sformatf("%s[%0d].valid", name, k), {8'h00, data_valid}, {8'h00, ev});
      if (ev) check($sformatf("%s[%0d].data", name, k), data, ed);
      check($sformatf("%s[%0d].done", name, k), {8'h00, frame_done}, {8'h00, edone});
   endtask

   task automatic apply_stimulus(input string name);
      int         n;
      int         j;
      logic       ev;
      logic [8:0] ed;
      logic       edone;
      n = vecs.size();
      for (int k = 0; k < n + LAT - 1; k++) begin
         if (k < n) begin
            pixel_valid = vecs[k].valid;
            pixel       = vecs[k].pixel;
         end else begin
            pixel_valid = 1'b0;
            pixel       = 1'b0;
         end
         @(posedge clk);
         #1;
         j = k - (LAT - 1);
         if (j >= 0) begin
            ev    = vecs[j].exp_valid;
            ed    = vecs[j].exp_data;
            edone = vecs[j].exp_done;
         end else begin
            ev    = 1'b0;
            ed    = 9'h000;
            edone = 1'b0;
         end
         check_output(name, k, ev, ed, edone);
      end
      pixel_valid = 1'b0;
      vecs.delete();
   endtask

   initial begin
      rst_n       = 1'b0;
      pixel       = 1'b0;
      pixel_valid = 1'b0;
      #12;
      check("reset.data", data, 9'h000);
      check("reset.valid", {8'h00, data_valid}, 9'h000);
      check("reset.done", {8'h00, frame_done}, 9'h000);
      @(negedge clk);
      rst_n = 1'b1;

      add_frame(20'hFFFFF, {6{9'h1FF}}, 1'b0);
      apply_stimulus("ones");

      add_frame(20'h00040, {9'h000, 9'h001, 9'h002, 9'h000, 9'h008, 9'h010}, 1'b0);
      apply_stimulus("single");

      add_frame(20'h00040, {9'h000, 9'h001, 9'h002, 9'h000, 9'h008, 9'h010}, 1'b1);
      apply_stimulus("toggled");

      add_frame(20'hFFFFF, {6{9'h1FF}}, 1'b0);
      add_frame(20'h00000, 54'h0, 1'b0);
      apply_stimulus("b2b");

      // Mid-frame reset: leave a nonzero held window, then cut the frame after 7 pixels.
      add_frame(20'hFFFFF, {6{9'h1FF}}, 1'b0);
      add_partial(7);
      apply_stimulus("prereset");
      check("hold.data", data, 9'h1FF);
      rst_n = 1'b0;
      #1;
      check("async_rst.data", data, 9'h000);
      check("async_rst.valid", {8'h00, data_valid}, 9'h000);
      check("async_rst.done", {8'h00, frame_done}, 9'h000);
      #3;
      rst_n = 1'b1;

      add_frame(20'h00040, {9'h000, 9'h001, 9'h002, 9'h000, 9'h008, 9'h010}, 1'b0);
      apply_stimulus("postreset");

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
      $finish;
   end

endmodule
